// File: rtl/lc3_pkg.sv
// LC-3 decode-stage shared definitions: opcodes, control encodings, E_Control layout.
package lc3_pkg;

  localparam int unsigned WORD_W  = 16;
  localparam int unsigned OPC_W   = 4;
  localparam int unsigned OPC_LSB = 12;
  localparam int unsigned E_CTL_W = 6;
  localparam int unsigned W_CTL_W = 2;

  // Immediate-mode flag for ADD/AND (instruction bit 5).
  localparam int unsigned IMM_FLAG_BIT = 5;

  // E_Control = {alu_ctl[1:0], pcsel1[1:0], pcsel2, op2sel}
  localparam int unsigned E_OP2SEL_BIT = 0;
  localparam int unsigned E_PCSEL2_BIT = 1;
  localparam int unsigned E_PCSEL1_LSB = 2;
  localparam int unsigned E_ALU_LSB    = 4;

  typedef enum logic [OPC_W-1:0] {
    OP_BR   = 4'b0000,
    OP_ADD  = 4'b0001,
    OP_LD   = 4'b0010,
    OP_ST   = 4'b0011,
    OP_JSR  = 4'b0100,
    OP_AND  = 4'b0101,
    OP_LDR  = 4'b0110,
    OP_STR  = 4'b0111,
    OP_RTI  = 4'b1000,
    OP_NOT  = 4'b1001,
    OP_LDI  = 4'b1010,
    OP_STI  = 4'b1011,
    OP_JMP  = 4'b1100,
    OP_RES  = 4'b1101,
    OP_LEA  = 4'b1110,
    OP_TRAP = 4'b1111
  } opcode_e;

  typedef enum logic [1:0] {
    ALU_ADD = 2'b00,
    ALU_AND = 2'b01,
    ALU_NOT = 2'b10
  } alu_ctl_e;

  typedef enum logic [1:0] {
    PC1_NONE = 2'b00,
    PC1_OFF9 = 2'b01,
    PC1_OFF6 = 2'b10,
    PC1_ZERO = 2'b11
  } pcsel1_e;

  typedef enum logic [W_CTL_W-1:0] {
    WB_ALU  = 2'b00,
    WB_MEM  = 2'b01,
    WB_ADDR = 2'b10
  } wb_sel_e;

endpackage

// File: rtl/decode_ctrl_lut.sv
// Combinational opcode-to-control lookup for the decode stage.
module decode_ctrl_lut
  import lc3_pkg::*;
(
  input  logic [WORD_W-1:0]  Instr_dout,
  output logic [E_CTL_W-1:0] e_control_c,
  output logic [W_CTL_W-1:0] w_control_c,
  output logic               mem_control_c,
  output logic               illegal_c
);

  opcode_e  opcode;
  alu_ctl_e alu_ctl;
  pcsel1_e  pcsel1;
  wb_sel_e  wb_sel;
  logic     pcsel2;
  logic     op2sel;

  // Register and offset fields are consumed downstream, not here.
  logic unused_fields;
  assign unused_fields = ^{Instr_dout[OPC_LSB-1:IMM_FLAG_BIT+1], Instr_dout[IMM_FLAG_BIT-1:0]};

  assign opcode = opcode_e'(Instr_dout[OPC_LSB +: OPC_W]);

  // Per-opcode control fields; unsupported opcodes leave everything at zero.
  always_comb begin
    alu_ctl       = ALU_ADD;
    pcsel1        = PC1_NONE;
    pcsel2        = 1'b0;
    op2sel        = 1'b0;
    wb_sel        = WB_ALU;
    mem_control_c = 1'b0;
    illegal_c     = 1'b0;
    case (opcode)
      OP_ADD: begin
        alu_ctl = ALU_ADD;
        op2sel  = ~Instr_dout[IMM_FLAG_BIT];
      end
      OP_AND: begin
        alu_ctl = ALU_AND;
        op2sel  = ~Instr_dout[IMM_FLAG_BIT];
      end
      OP_NOT: alu_ctl = ALU_NOT;
      OP_BR, OP_ST: begin
        pcsel1 = PC1_OFF9;
        pcsel2 = 1'b1;
      end
      OP_LD: begin
        pcsel1 = PC1_OFF9;
        pcsel2 = 1'b1;
        wb_sel = WB_MEM;
      end
      OP_LDI: begin
        pcsel1        = PC1_OFF9;
        pcsel2        = 1'b1;
        wb_sel        = WB_MEM;
        mem_control_c = 1'b1;
      end
      OP_STI: begin
        pcsel1        = PC1_OFF9;
        pcsel2        = 1'b1;
        mem_control_c = 1'b1;
      end
      OP_LEA: begin
        pcsel1 = PC1_OFF9;
        pcsel2 = 1'b1;
        wb_sel = WB_ADDR;
      end
      OP_LDR: begin
        pcsel1 = PC1_OFF6;
        wb_sel = WB_MEM;
      end
      OP_STR: pcsel1 = PC1_OFF6;
      OP_JMP: pcsel1 = PC1_ZERO;
      OP_JSR, OP_RTI, OP_RES, OP_TRAP: illegal_c = 1'b1;
      default: illegal_c = 1'b1;
    endcase
  end

  // Pack fields into the execute-stage control word.
  always_comb begin
    e_control_c                          = '0;
    e_control_c[E_ALU_LSB +: 2]          = alu_ctl;
    e_control_c[E_PCSEL1_LSB +: 2]       = pcsel1;
    e_control_c[E_PCSEL2_BIT]            = pcsel2;
    e_control_c[E_OP2SEL_BIT]            = op2sel;
    w_control_c                          = wb_sel;
  end

endmodule

// File: rtl/decode.sv
// LC-3 decode stage: registers IR/npc and the downstream control bundles.
module decode
  import lc3_pkg::*;
#(
  parameter int unsigned WIDTH = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               enable_decode,
  input  logic [WIDTH-1:0]   Instr_dout,
  input  logic [WIDTH-1:0]   npc_in,
  output logic [WIDTH-1:0]   IR,
  output logic [WIDTH-1:0]   npc_out,
  output logic [E_CTL_W-1:0] E_Control,
  output logic [W_CTL_W-1:0] W_Control,
  output logic               Mem_Control,
  output logic               illegal_op
);

  logic [E_CTL_W-1:0] e_control_c;
  logic [W_CTL_W-1:0] w_control_c;
  logic               mem_control_c;
  logic               illegal_c;

  decode_ctrl_lut u_lut (
    .Instr_dout    (WORD_W'(Instr_dout)),
    .e_control_c   (e_control_c),
    .w_control_c   (w_control_c),
    .mem_control_c (mem_control_c),
    .illegal_c     (illegal_c)
  );

  // Reset wins over enable; an enabled cycle replaces every output at once.
  always_ff @(posedge clk) begin
    if (rst) begin
      IR          <= '0;
      npc_out     <= '0;
      E_Control   <= '0;
      W_Control   <= '0;
      Mem_Control <= 1'b0;
      illegal_op  <= 1'b0;
    end else if (enable_decode) begin
      IR          <= Instr_dout;
      npc_out     <= npc_in;
      E_Control   <= e_control_c;
      W_Control   <= w_control_c;
      Mem_Control <= mem_control_c;
      illegal_op  <= illegal_c;
    end
  end

endmodule

// File: tb/tb_decode.sv
// Scoreboard bench for the LC-3 decode stage.
module tb_decode;

  logic        clk = 1'b0;
  logic        rst;
  logic        enable_decode;
  logic [15:0] Instr_dout;
  logic [15:0] npc_in;
  logic [15:0] IR;
  logic [15:0] npc_out;
  logic [5:0]  E_Control;
  logic [1:0]  W_Control;
  logic        Mem_Control;
  logic        illegal_op;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct packed {
    logic [15:0] ir;
    logic [15:0] npc;
    logic [5:0]  e;
    logic [1:0]  w;
    logic        m;
    logic        ill;
  } exp_t;

  exp_t exp_q[$];
  exp_t model_state = '0;

  always #5 clk = ~clk;

  decode #(.WIDTH(16)) dut (
    .clk           (clk),
    .rst           (rst),
    .enable_decode (enable_decode),
    .Instr_dout    (Instr_dout),
    .npc_in        (npc_in),
    .IR            (IR),
    .npc_out       (npc_out),
    .E_Control     (E_Control),
    .W_Control     (W_Control),
    .Mem_Control   (Mem_Control),
    .illegal_op    (illegal_op)
  );

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%h expected 0x%h", tag, got, exp);
    end
  endtask

  // Reference decode table written straight from the opcode list.
  function automatic exp_t model(input logic [15:0] instr, input logic [15:0] npc);
    exp_t r;
    logic i5;
    i5 = instr[5];
    r = '0;
    r.ir  = instr;
    r.npc = npc;
    case (instr[15:12])
      4'h1: r.e = {5'b00000, ~i5};
      4'h5: r.e = {5'b01000, ~i5};
      4'h9: r.e = 6'b100000;
      4'h0: r.e = 6'h06;
      4'h3: r.e = 6'h06;
      4'h2: begin r.e = 6'h06; r.w = 2'b01; end
      4'hA: begin r.e = 6'h06; r.w = 2'b01; r.m = 1'b1; end
      4'hB: begin r.e = 6'h06; r.m = 1'b1; end
      4'hE: begin r.e = 6'h06; r.w = 2'b10; end
      4'h6: begin r.e = 6'h08; r.w = 2'b01; end
      4'h7: r.e = 6'h08;
      4'hC: r.e = 6'h0C;
      default: r.ill = 1'b1;
    endcase
    return r;
  endfunction

  // Drive one cycle, predict the registered result, compare after the edge.
  task automatic step(input logic r, input logic en, input logic [15:0] instr, input logic [15:0] npc);
    exp_t e;
    @(negedge clk);
    rst = r;
    enable_decode = en;
    Instr_dout = instr;
    npc_in = npc;
    if (r) model_state = '0;
    else if (en) model_state = model(instr, npc);
    exp_q.push_back(model_state);
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) begin
      n_checks++;
      n_errors++;
      $display("FAIL scoreboard_empty: got 0 entries expected 1");
    end else begin
      e = exp_q.pop_front();
      check("ir",      IR,                   e.ir);
      check("npc_out", npc_out,              e.npc);
      check("e_ctl",   16'(E_Control),       16'(e.e));
      check("w_ctl",   16'(W_Control),       16'(e.w));
      check("mem_ctl", 16'(Mem_Control),     16'(e.m));
      check("illegal", 16'(illegal_op),      16'(e.ill));
    end
  endtask

  initial begin
    rst = 1'b1;
    enable_decode = 1'b0;
    Instr_dout = '0;
    npc_in = '0;

    // Reset with enable high and a live instruction: everything stays zero.
    step(1'b1, 1'b1, 16'h12A3, 16'h3001);
    check("tp_reset_ir", IR, 16'h0000);
    step(1'b0, 1'b1, 16'h12A3, 16'h3001);
    check("tp_add_ir",  IR, 16'h12A3);
    check("tp_add_npc", npc_out, 16'h3001);
    check("tp_add_e",   16'(E_Control), 16'h0000);

    step(1'b0, 1'b1, 16'h5705, 16'h3002);
    check("tp_and_e", 16'(E_Control), 16'h0011);
    step(1'b0, 1'b1, 16'h607E, 16'h3003);
    check("tp_ldr_e", 16'(E_Control), 16'h0008);
    check("tp_ldr_w", 16'(W_Control), 16'h0001);
    step(1'b0, 1'b1, 16'hB405, 16'h3004);
    check("tp_sti_e", 16'(E_Control), 16'h0006);
    check("tp_sti_m", 16'(Mem_Control), 16'h0001);
    step(1'b0, 1'b1, 16'hEFFF, 16'h3005);
    check("tp_lea_e", 16'(E_Control), 16'h0006);
    check("tp_lea_w", 16'(W_Control), 16'h0002);
    step(1'b0, 1'b1, 16'hC0C0, 16'h3006);
    check("tp_jmp_e", 16'(E_Control), 16'h000C);

    // Hold for three cycles with a different instruction on the bus.
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 16'hFFFF, 16'hAAAA);
    check("tp_hold_ir", IR, 16'hC0C0);

    step(1'b0, 1'b1, 16'hF025, 16'h3007);
    check("tp_trap_ill", 16'(illegal_op), 16'h0001);
    check("tp_trap_e",   16'(E_Control), 16'h0000);
    step(1'b0, 1'b1, 16'h12A3, 16'h3008);
    check("tp_clr_ill", 16'(illegal_op), 16'h0000);
    step(1'b1, 1'b1, 16'h5705, 16'h3009);
    check("tp_rst_mid_ir", IR, 16'h0000);

    // Every opcode once, both imm5 and register forms.
    for (int op = 0; op < 16; op++) begin
      step(1'b0, 1'b1, 16'(op << 12) | 16'h0020, 16'(op));
      step(1'b0, 1'b1, 16'(op << 12) | 16'h0A05, 16'(op + 100));
    end

    // Illegal flag persists across holds, then reset clears it.
    step(1'b0, 1'b1, 16'h4000, 16'h1111);
    step(1'b0, 1'b0, 16'h1000, 16'h2222);
    step(1'b1, 1'b0, 16'h1000, 16'h2222);
    step(1'b0, 1'b1, 16'hD123, 16'h3333);

    // Random mix of enables, holds and occasional resets.
    for (int i = 0; i < 80; i++)
      step(($urandom_range(0, 15) == 0), ($urandom_range(0, 3) != 0),
           16'($urandom), 16'($urandom));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
